// File: rtl/de2_board_pkg.sv
`default_nettype none
// ============================================================================
// Module   : de2_board_pkg
// Brief    : Shared run-mode types and default timing constants for the DE2
//            board wrapper and its run controller.
// Revision : 1.0 - initial release
// ============================================================================
package de2_board_pkg;

    typedef enum logic [1:0] {
        MODE_SLOW = 2'b00,
        MODE_FAST = 2'b01,
        MODE_STEP = 2'b10
    } mode_e;

    typedef enum logic [1:0] {
        ST_SLOW      = 2'b00,
        ST_FAST      = 2'b01,
        ST_STEP_IDLE = 2'b10,
        ST_STEP_HOLD = 2'b11
    } run_state_e;

    localparam int unsigned c_DIV_SLOW_DEFAULT   = 25_000_000;
    localparam int unsigned c_DEB_CYCLES_DEFAULT = 1_000_000;
    localparam int unsigned c_CNT_W_DEFAULT      = 16;

    // Entering STEP always lands in the idle state so a held key cannot fire.
    function automatic run_state_e mode_entry_state(input mode_e m);
        case (m)
            MODE_FAST: return ST_FAST;
            MODE_STEP: return ST_STEP_IDLE;
            default:   return ST_SLOW;
        endcase
    endfunction

    function automatic mode_e state_to_mode(input run_state_e s);
        case (s)
            ST_FAST:      return MODE_FAST;
            ST_STEP_IDLE: return MODE_STEP;
            ST_STEP_HOLD: return MODE_STEP;
            default:      return MODE_SLOW;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module   : btn_debounce
// Brief    : Active-low pushbutton synchronizer and stability debouncer with
//            one-cycle rise/fall strobes of the debounced level.
// Revision : 1.0 - initial release
// ============================================================================
module btn_debounce #(
    parameter int unsigned DEB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn_n,
    output logic o_rise,
    output logic o_fall
);

    localparam int unsigned        c_CNT_W    = $clog2(DEB_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEB_CYCLES - 1);

    logic               r_meta;
    logic               r_sync;
    logic               r_level;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_rise;
    logic               r_fall;

    logic w_differ;
    logic w_flip;

    assign w_differ = r_sync ^ r_level;
    assign w_flip   = w_differ && (r_cnt == c_CNT_LAST);

    // Idle level is "released" so a reset never looks like a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta  <= 1'b1;
            r_sync  <= 1'b1;
            r_level <= 1'b1;
            r_cnt   <= '0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_meta <= i_btn_n;
            r_sync <= r_meta;
            r_rise <= w_flip &  r_sync;
            r_fall <= w_flip & ~r_sync;
            if (w_flip) begin
                r_level <= r_sync;
                r_cnt   <= '0;
            end else if (w_differ) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_rise = r_rise;
    assign o_fall = r_fall;

endmodule
`default_nettype wire

// File: rtl/de2_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : de2_run_ctrl
// Brief    : DE2 run controller producing the core clock-enable in FAST, SLOW
//            or single-STEP mode, plus heartbeat LED and retired-step count.
// Revision : 1.0 - initial release
// ============================================================================
module de2_run_ctrl
    import de2_board_pkg::*;
#(
    parameter int unsigned DIV_SLOW   = c_DIV_SLOW_DEFAULT,
    parameter int unsigned DEB_CYCLES = c_DEB_CYCLES_DEFAULT,
    parameter int unsigned CNT_W      = c_CNT_W_DEFAULT
) (
    input  logic             CLOCK_50,
    input  logic             rst_n,
    input  logic             sw_fast,
    input  logic             sw_step,
    input  logic             key_step_n,
    output logic             cpu_ce,
    output logic             heartbeat,
    output logic [1:0]       mode,
    output logic [CNT_W-1:0] ce_count
);

    localparam int unsigned        c_DIV_W    = $clog2(DIV_SLOW);
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(DIV_SLOW - 1);

    logic               r_sw_fast_meta;
    logic               r_sw_fast_sync;
    logic               r_sw_step_meta;
    logic               r_sw_step_sync;
    run_state_e         r_state;
    logic               r_cpu_ce;
    logic [CNT_W-1:0]   r_ce_count;
    logic [c_DIV_W-1:0] r_div;
    logic [c_DIV_W-1:0] r_hb_cnt;
    logic               r_heartbeat;

    mode_e      w_req;
    run_state_e w_next;
    logic       w_ce_next;
    logic       w_key_rise;
    logic       w_key_fall;

    btn_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_key_step (
        .clk     (CLOCK_50),
        .rst_n   (rst_n),
        .i_btn_n (key_step_n),
        .o_rise  (w_key_rise),
        .o_fall  (w_key_fall)
    );

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_sw_fast_meta <= 1'b0;
            r_sw_fast_sync <= 1'b0;
            r_sw_step_meta <= 1'b0;
            r_sw_step_sync <= 1'b0;
        end else begin
            r_sw_fast_meta <= sw_fast;
            r_sw_fast_sync <= r_sw_fast_meta;
            r_sw_step_meta <= sw_step;
            r_sw_step_sync <= r_sw_step_meta;
        end
    end

    always_comb begin
        w_req = MODE_SLOW;
        if (r_sw_step_sync) begin
            w_req = MODE_STEP;
        end else if (r_sw_fast_sync) begin
            w_req = MODE_FAST;
        end
    end

    // A mode request always wins over the step handshake; the enable is
    // derived from the next state for FAST so it is live on the entry cycle.
    always_comb begin
        w_next = r_state;
        if (state_to_mode(r_state) != w_req) begin
            w_next = mode_entry_state(w_req);
        end else begin
            case (r_state)
                ST_STEP_IDLE: if (w_key_fall) w_next = ST_STEP_HOLD;
                ST_STEP_HOLD: if (w_key_rise) w_next = ST_STEP_IDLE;
                default:      w_next = r_state;
            endcase
        end

        w_ce_next = (w_next == ST_FAST)
                  | ((r_state == ST_SLOW) && (r_div == c_DIV_LAST))
                  | ((r_state == ST_STEP_IDLE) && w_key_fall);
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_SLOW;
            r_cpu_ce   <= 1'b0;
            r_ce_count <= '0;
        end else begin
            r_state  <= w_next;
            r_cpu_ce <= w_ce_next;
            if (w_ce_next) begin
                r_ce_count <= r_ce_count + 1'b1;
            end
        end
    end

    // Held at zero outside SLOW so every SLOW entry starts a full period.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= '0;
        end else if ((r_state != ST_SLOW) || (r_div == c_DIV_LAST)) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_hb_cnt    <= '0;
            r_heartbeat <= 1'b0;
        end else if (r_hb_cnt == c_DIV_LAST) begin
            r_hb_cnt    <= '0;
            r_heartbeat <= ~r_heartbeat;
        end else begin
            r_hb_cnt <= r_hb_cnt + 1'b1;
        end
    end

    assign cpu_ce    = r_cpu_ce;
    assign heartbeat = r_heartbeat;
    assign mode      = state_to_mode(r_state);
    assign ce_count  = r_ce_count;

endmodule
`default_nettype wire

// File: tb/tb_de2_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_de2_run_ctrl
// Brief    : Directed self-checking bench for de2_run_ctrl (DIV_SLOW=4,
//            DEB_CYCLES=3, CNT_W=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_de2_run_ctrl;

    logic       clk        = 1'b0;
    logic       rst_n      = 1'b0;
    logic       sw_fast    = 1'b0;
    logic       sw_step    = 1'b0;
    logic       key_step_n = 1'b1;
    logic       cpu_ce;
    logic       heartbeat;
    logic [1:0] mode;
    logic [3:0] ce_count;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    de2_run_ctrl #(
        .DIV_SLOW   (4),
        .DEB_CYCLES (3),
        .CNT_W      (4)
    ) dut (
        .CLOCK_50   (clk),
        .rst_n      (rst_n),
        .sw_fast    (sw_fast),
        .sw_step    (sw_step),
        .key_step_n (key_step_n),
        .cpu_ce     (cpu_ce),
        .heartbeat  (heartbeat),
        .mode       (mode),
        .ce_count   (ce_count)
    );

    always #5 clk = ~clk;

    // Edges since the last reset release; the heartbeat reference.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            sw_fast = i[0];
            sw_step = i[1];
            tick();
            n_tests++;
            if ({cpu_ce, heartbeat, mode, ce_count} !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_hold i=%0d got ce=%b hb=%b mode=%b cnt=%0d exp all 0",
                         i, cpu_ce, heartbeat, mode, ce_count);
            end
        end
        sw_fast = 1'b0;
        sw_step = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_slow();
        for (int i = 1; i <= 12; i++) begin
            tick();
            n_tests++;
            if (cpu_ce !== ((i % 4) == 0)) begin
                n_fail++;
                $display("FAIL slow_ce i=%0d got %b exp %b", i, cpu_ce, ((i % 4) == 0));
            end
        end
        n_tests++;
        if (ce_count !== 4'd3 || mode !== 2'b00) begin
            n_fail++;
            $display("FAIL slow_count got cnt=%0d mode=%b exp cnt=3 mode=00", ce_count, mode);
        end
    endtask

    task automatic test_fast();
        sw_fast = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_tests++;
            if (mode !== ((i == 3) ? 2'b01 : 2'b00) || cpu_ce !== (i == 3)) begin
                n_fail++;
                $display("FAIL fast_entry i=%0d got mode=%b ce=%b exp mode=%b ce=%b",
                         i, mode, cpu_ce, ((i == 3) ? 2'b01 : 2'b00), (i == 3));
            end
        end
        n_tests++;
        if (ce_count !== 4'd4) begin
            n_fail++;
            $display("FAIL fast_first_count got %0d exp 4", ce_count);
        end
        for (int i = 1; i <= 19; i++) begin
            tick();
            n_tests++;
            if (cpu_ce !== 1'b1) begin
                n_fail++;
                $display("FAIL fast_ce i=%0d got %b exp 1", i, cpu_ce);
            end
        end
        n_tests++;
        if (ce_count !== 4'd7) begin
            n_fail++;
            $display("FAIL fast_wrap got %0d exp 7", ce_count);
        end
    endtask

    task automatic test_step_press();
        logic [5:0] glitch;
        glitch = 6'b100100;
        sw_step = 1'b1;
        tick();
        n_tests++;
        if (cpu_ce !== 1'b1 || ce_count !== 4'd8) begin
            n_fail++;
            $display("FAIL step_entry1 got ce=%b cnt=%0d exp ce=1 cnt=8", cpu_ce, ce_count);
        end
        tick();
        n_tests++;
        if (cpu_ce !== 1'b1 || ce_count !== 4'd9) begin
            n_fail++;
            $display("FAIL step_entry2 got ce=%b cnt=%0d exp ce=1 cnt=9", cpu_ce, ce_count);
        end
        tick();
        n_tests++;
        if (mode !== 2'b10 || cpu_ce !== 1'b0 || ce_count !== 4'd9) begin
            n_fail++;
            $display("FAIL step_entry3 got mode=%b ce=%b cnt=%0d exp mode=10 ce=0 cnt=9",
                     mode, cpu_ce, ce_count);
        end
        for (int i = 0; i < 6; i++) begin
            key_step_n = glitch[i];
            tick();
            n_tests++;
            if (cpu_ce !== 1'b0) begin
                n_fail++;
                $display("FAIL step_bounce i=%0d got %b exp 0", i, cpu_ce);
            end
        end
        key_step_n = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            n_tests++;
            if (cpu_ce !== (i == 6)) begin
                n_fail++;
                $display("FAIL step_press i=%0d got %b exp %b", i, cpu_ce, (i == 6));
            end
        end
        n_tests++;
        if (ce_count !== 4'd10 || mode !== 2'b10) begin
            n_fail++;
            $display("FAIL step_count got cnt=%0d mode=%b exp cnt=10 mode=10", ce_count, mode);
        end
    endtask

    task automatic test_held_toggle();
        logic [1:0] exp_mode [1:5];
        exp_mode = '{2'b10, 2'b10, 2'b00, 2'b00, 2'b10};
        sw_fast = 1'b0;
        sw_step = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            if (i == 2) sw_step = 1'b1;
            n_tests++;
            if (mode !== exp_mode[i] || cpu_ce !== 1'b0) begin
                n_fail++;
                $display("FAIL held_toggle i=%0d got mode=%b ce=%b exp mode=%b ce=0",
                         i, mode, cpu_ce, exp_mode[i]);
            end
        end
        for (int i = 1; i <= 14; i++) begin
            if (i == 7) key_step_n = 1'b1;
            tick();
            n_tests++;
            if (cpu_ce !== 1'b0) begin
                n_fail++;
                $display("FAIL held_no_pulse i=%0d got %b exp 0", i, cpu_ce);
            end
        end
        key_step_n = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            n_tests++;
            if (cpu_ce !== (i == 6)) begin
                n_fail++;
                $display("FAIL held_repress i=%0d got %b exp %b", i, cpu_ce, (i == 6));
            end
        end
        n_tests++;
        if (ce_count !== 4'd11) begin
            n_fail++;
            $display("FAIL held_count got %0d exp 11", ce_count);
        end
        key_step_n = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            n_tests++;
            if (cpu_ce !== 1'b0) begin
                n_fail++;
                $display("FAIL release_no_pulse i=%0d got %b exp 0", i, cpu_ce);
            end
        end
    endtask

    task automatic test_heartbeat();
        logic [1:0] sw_seq [0:3];
        logic       exp_hb;
        sw_seq = '{2'b00, 2'b01, 2'b10, 2'b00};
        for (int m = 0; m < 4; m++) begin
            {sw_step, sw_fast} = sw_seq[m];
            for (int i = 0; i < 10; i++) begin
                tick();
                exp_hb = ((cyc / 4) % 2) == 1;
                n_tests++;
                if (heartbeat !== exp_hb) begin
                    n_fail++;
                    $display("FAIL heartbeat m=%0d cyc=%0d got %b exp %b", m, cyc, heartbeat, exp_hb);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        sw_fast = 1'b0;
        sw_step = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        key_step_n = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        n_tests++;
        if (mode !== 2'b10) begin
            n_fail++;
            $display("FAIL hold_mode got %b exp 10", mode);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({cpu_ce, heartbeat, mode, ce_count} !== 8'h00) begin
            n_fail++;
            $display("FAIL async_rst_hold got ce=%b hb=%b mode=%b cnt=%0d exp all 0",
                     cpu_ce, heartbeat, mode, ce_count);
        end
        key_step_n = 1'b1;
        sw_step    = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 1; i <= 2; i++) begin
            tick();
            n_tests++;
            if (cpu_ce !== 1'b0) begin
                n_fail++;
                $display("FAIL slow_pre_rst i=%0d got %b exp 0", i, cpu_ce);
            end
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({cpu_ce, heartbeat, mode, ce_count} !== 8'h00) begin
            n_fail++;
            $display("FAIL async_rst_slow got ce=%b hb=%b mode=%b cnt=%0d exp all 0",
                     cpu_ce, heartbeat, mode, ce_count);
        end
        tick();
        rst_n = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            n_tests++;
            if (cpu_ce !== (i == 4)) begin
                n_fail++;
                $display("FAIL slow_restart i=%0d got %b exp %b", i, cpu_ce, (i == 4));
            end
        end
        n_tests++;
        if (ce_count !== 4'd1 || heartbeat !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_state got cnt=%0d hb=%b exp cnt=1 hb=1", ce_count, heartbeat);
        end
    endtask

    initial begin
        test_reset();
        test_slow();
        test_fast();
        test_step_press();
        test_held_toggle();
        test_heartbeat();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
